free_list: RTL and testbench
============================

# free_list

Circular FIFO of free physical register tags for the R10K rename stage. It hands new destination tags to dispatch, where they become the ROB's `disp_rd_new_prf_i`. It reclaims the previous mapping (`commit_old_prf_o`) when the ROB retires a writing instruction. On a ROB flush it rolls the allocation pointer back to the retirement pointer, so every tag held by a squashed instruction is reclaimed in one cycle.

## Interface
- `PHYS_REGS`, default 128: physical register count. Tag width `PW = $clog2(PHYS_REGS)`.
- `ARCH_REGS`, default 64: architectural register count. Must be less than `PHYS_REGS`.
- `DISPATCH_WIDTH`, default 2: allocation lanes.
- `COMMIT_WIDTH`, default 2: free lanes.
- Derived: `FL_DEPTH = PHYS_REGS - ARCH_REGS` (default 64). Pointer width `$clog2(FL_DEPTH)`. Count width `$clog2(FL_DEPTH)+1`.

Ports:
- `clk`, input, 1: the single clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `alloc_req_i`, input, `DISPATCH_WIDTH`: lane wants a destination tag.
- `alloc_gnt_o`, output, `DISPATCH_WIDTH`: lane granted this cycle (combinational).
- `alloc_prf_o [DISPATCH_WIDTH]`, output, `PW`: tag for the lane; valid only when granted.
- `free_valid_i`, input, `COMMIT_WIDTH`: driven as commit_valid & commit_rd_wen.
- `free_prf_i [COMMIT_WIDTH]`, input, `PW`: old tag to return.
- `flush_i`, input, 1: ROB flush; squash all in-flight allocations.
- `free_count_o`, output, count width: registered number of free tags.
- `error_o`, output, 1: sticky double-free/overflow flag (see Configuration).

## Operation
State:
- `fl_mem[FL_DEPTH]` of `PW`-bit tags.
- Pointers: `head` (allocation), `tail` (free), `rhead` (retirement head).
- `count`.

All pointers wrap explicitly: FL_DEPTH-1 → 0. No power-of-two assumption.

Allocation (combinational):
- `k` = number of granted lanes below lane `i`.
- `alloc_gnt_o[i] = alloc_req_i[i] && !flush_i && (count > k)`.
- `alloc_prf_o[i] = fl_mem[(head+k) wrap]`.
- Grants are prefix-packed: a non-requesting lane consumes no entry.
- On the clock edge, `head` advances by popcount(`alloc_gnt_o`).

Free:
- Valid lanes are compacted in lane order.
- The j-th valid lane writes `fl_mem[(tail+j) wrap]`.
- `tail` and `rhead` each advance by popcount(`free_valid_i`).
- One retired writer equals one retired allocation, so `rhead` tracks the oldest non-retired allocation.

Count:
- Normal cycle: `count_next = count + popcount(free) - popcount(gnt)`.

Flush:
- Frees presented in the same cycle are still written; the flushing instruction's own commit is valid.
- `head <= rhead_next`, where `rhead_next` = `rhead` plus this cycle's frees.
- `count <= FL_DEPTH`.
- No grants are issued in the flush cycle.
- Invariant: after a flush, every non-architectural tag is free.

Reset (asynchronous, `reset_n` low):
- `head = tail = rhead = 0`, `count = FL_DEPTH`.
- `fl_mem[i] = ARCH_REGS + i`.
- `error_o = 0`.
- Outputs after reset: `free_count_o = FL_DEPTH`, `alloc_prf_o[k] = ARCH_REGS+k`, `alloc_gnt_o` = prefix of `alloc_req_i`.
- Reset asserted mid-operation discards all state immediately.

## Timing
- Grant and tag are combinational from registered state, available in the same cycle as the request (0-cycle latency).
- A freed tag becomes allocatable in the cycle after `free_valid_i`. There is no same-cycle bypass.
- Allocate and free in the same cycle are both legal, including when `count = 0` (no grant) or `count = FL_DEPTH`.
- `free_count_o` reflects state at the start of the cycle.
- `flush_i` has priority over allocation. Its effect is visible in the next cycle.

## Configuration
`FREELIST_CHECK_EN`:
- Defined: adds a `PHYS_REGS`-bit in-list vector. Reset value is 1 for tags `ARCH_REGS..PHYS_REGS-1`, 0 otherwise. Allocation clears the bit; free sets it; flush sets the bits of all reclaimed tags.
- `error_o` sets (sticky until reset) when any of these occur:
  - a free hits a tag whose bit is already 1;
  - two lanes free the same tag in one cycle;
  - `count_next` would exceed `FL_DEPTH`.
- Free-list data behaviour is otherwise unchanged.
- Not defined: no vector; `error_o` is tied to 0.

## Test plan
- Reset, `alloc_req_i=2'b11` every cycle → tags 64,65 … 126,127 over 32 cycles; cycle 33 gives `alloc_gnt_o=2'b00`, `free_count_o=0`.
- `count=1`, `alloc_req_i=2'b11` → `alloc_gnt_o=2'b01`; the lane-0 tag is the head entry; next cycle `free_count_o=0`.
- From empty, free tags 5 and 9 on lanes 0,1 → next cycle `free_count_o=2`; `alloc_req_i=2'b10` gets tag 5 on lane 1 with `alloc_gnt_o=2'b10`.
- Allocate 10 tags, free 3, then `flush_i` with 1 simultaneous free → next cycle `free_count_o=64`; the next grant returns the tag at the old `rhead+4`.
- Run 200 cycles of mixed alloc/free keeping `count` between 0 and 64 → pointers wrap at 63→0; tags returned in FIFO order match a scoreboard.
- With `FREELIST_CHECK_EN`, free tag 70 while it is still free → `error_o=1` next cycle and it stays 1; without the macro, `error_o=0`.

Source files
------------

// File: rtl/free_list.sv
// Circular free list of physical register tags for R10K-style renaming: allocation, reclaim on retire, flush rollback.
// Optional FREELIST_CHECK_EN macro adds an in-list vector that flags double frees and overflow on error_o.
module free_list #(
   parameter int PHYS_REGS      = 128,
   parameter int ARCH_REGS      = 64,
   parameter int DISPATCH_WIDTH = 2,
   parameter int COMMIT_WIDTH   = 2,
   localparam int PW            = $clog2(PHYS_REGS),
   localparam int FL_DEPTH      = PHYS_REGS - ARCH_REGS,
   localparam int PTR_W         = $clog2(FL_DEPTH),
   localparam int CNT_W         = $clog2(FL_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [DISPATCH_WIDTH-1:0] alloc_req_i,
   output logic [DISPATCH_WIDTH-1:0] alloc_gnt_o,
   output logic [PW-1:0]             alloc_prf_o [DISPATCH_WIDTH],
   input  logic [COMMIT_WIDTH-1:0]   free_valid_i,
   input  logic [PW-1:0]             free_prf_i [COMMIT_WIDTH],
   input  logic                      flush_i,
   output logic [CNT_W-1:0]          free_count_o,
   output logic                      error_o
);

   localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(FL_DEPTH);

   // Explicit modulo add; lane counts never exceed the depth, so one subtract suffices.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
      logic [CNT_W:0] s;
      s = {2'b00, p} + {1'b0, n};
      if (s >= DEPTH_X) s = s - DEPTH_X;
      return s[PTR_W-1:0];
   endfunction

   logic [PW-1:0]    fl_mem_q [FL_DEPTH];
   logic [PW-1:0]    fl_mem_d [FL_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] rhead_q, rhead_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] n_gnt, n_free;
   logic [CNT_W:0]   cnt_sum;

   always_comb begin
      n_gnt = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         alloc_gnt_o[i] = 1'b0;
         alloc_prf_o[i] = fl_mem_q[wrap_add(head_q, n_gnt)];
         if (alloc_req_i[i] && !flush_i && (count_q > n_gnt)) begin
            alloc_gnt_o[i] = 1'b1;
            n_gnt          = n_gnt + 1'b1;
         end
      end
   end

   always_comb begin
      n_free   = '0;
      fl_mem_d = fl_mem_q;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (free_valid_i[i]) begin
            fl_mem_d[wrap_add(tail_q, n_free)] = free_prf_i[i];
            n_free = n_free + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_sum = {1'b0, count_q} + {1'b0, n_free} - {1'b0, n_gnt};
      tail_d  = wrap_add(tail_q, n_free);
      rhead_d = wrap_add(rhead_q, n_free);
      if (flush_i) begin
         head_d  = rhead_d;
         count_d = DEPTH_X[CNT_W-1:0];
      end else begin
         head_d  = wrap_add(head_q, n_gnt);
         count_d = cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         rhead_q <= '0;
         count_q <= DEPTH_X[CNT_W-1:0];
         for (int i = 0; i < FL_DEPTH; i++) fl_mem_q[i] <= PW'(ARCH_REGS + i);
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         rhead_q  <= rhead_d;
         count_q  <= count_d;
         fl_mem_q <= fl_mem_d;
      end
   end

   assign free_count_o = count_q;

`ifdef FREELIST_CHECK_EN
   logic [PHYS_REGS-1:0] in_list_q, in_list_d;
   logic                 error_q, error_d;
   logic [CNT_W:0]       squash_span;
   logic [CNT_W:0]       dist;
   logic [CNT_W:0]       pos;
   logic [CNT_W:0]       rh_ext;

   always_comb begin
      in_list_d   = in_list_q;
      error_d     = error_q;
      squash_span = DEPTH_X - ({1'b0, count_q} + {1'b0, n_free});
      rh_ext      = {2'b00, rhead_d};
      pos         = '0;
      dist        = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++)
         if (alloc_gnt_o[i]) in_list_d[alloc_prf_o[i]] = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (free_valid_i[i]) begin
            if (in_list_q[free_prf_i[i]]) error_d = 1'b1;
            for (int m = 0; m < i; m++)
               if (free_valid_i[m] && (free_prf_i[m] == free_prf_i[i])) error_d = 1'b1;
            in_list_d[free_prf_i[i]] = 1'b1;
         end
      end
      if (cnt_sum > DEPTH_X) error_d = 1'b1;
      // Squashed allocations occupy [rhead_d, head_q) after this cycle's retirements.
      if (flush_i) begin
         for (int p = 0; p < FL_DEPTH; p++) begin
            pos  = (CNT_W+1)'(p);
            dist = (pos >= rh_ext) ? (pos - rh_ext) : (pos + DEPTH_X - rh_ext);
            if (dist < squash_span) in_list_d[fl_mem_q[p]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         error_q <= 1'b0;
         for (int i = 0; i < PHYS_REGS; i++) in_list_q[i] <= (i >= ARCH_REGS);
      end else begin
         error_q   <= error_d;
         in_list_q <= in_list_d;
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a queue-based model of free, in-flight and architectural tags.
module tb_free_list;
   localparam int ARCH  = 64;
   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] alloc_req;
   logic [1:0] alloc_gnt;
   logic [6:0] alloc_prf [2];
   logic [1:0] free_valid;
   logic [6:0] free_prf [2];
   logic       flush;
   logic [6:0] free_count;
   logic       error;

   always #5 clk = ~clk;

   free_list dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .alloc_req_i  (alloc_req),
      .alloc_gnt_o  (alloc_gnt),
      .alloc_prf_o  (alloc_prf),
      .free_valid_i (free_valid),
      .free_prf_i   (free_prf),
      .flush_i      (flush),
      .free_count_o (free_count),
      .error_o      (error)
   );

   int compared   = 0;
   int mismatched = 0;
   int free_q[$];
   int inflight_q[$];
   int pool_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      free_q     = {};
      inflight_q = {};
      pool_q     = {};
      for (int i = 0; i < DEPTH; i++) free_q.push_back(ARCH + i);
      for (int i = 0; i < ARCH; i++) pool_q.push_back(i);
   endtask

   task automatic pool_remove(input int t);
      for (int i = 0; i < pool_q.size(); i++)
         if (pool_q[i] == t) begin
            pool_q.delete(i);
            return;
         end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst_count", free_count, DEPTH);
      check_val("rst_error", error, 0);
      model_reset();
      @(negedge clk);
      alloc_req  = 2'b00;
      free_valid = 2'b00;
      flush      = 1'b0;
      reset_n    = 1'b1;
   endtask

   // One transaction: drive at negedge, compare combinational outputs, then advance the model.
   task automatic cycle(input logic [1:0] req, input logic [1:0] fv, input int t0, input int t1, input logic fl);
      int k;
      int tg[2];
      bit g;
      @(negedge clk);
      tg[0] = t0;
      tg[1] = t1;
      alloc_req   = req;
      free_valid  = fv;
      free_prf[0] = tg[0][6:0];
      free_prf[1] = tg[1][6:0];
      flush       = fl;
      #1;
      check_val("free_count", free_count, free_q.size());
      check_val("error", error, 0);
      k = 0;
      for (int i = 0; i < 2; i++) begin
         g = req[i] && !fl && (free_q.size() > k);
         check_val($sformatf("gnt%0d", i), alloc_gnt[i], int'(g));
         if (g) begin
            check_val($sformatf("prf%0d", i), alloc_prf[i], free_q[k]);
            k++;
         end
      end
      $display("txn req=%b gnt=%b prf=%0d,%0d free=%b(%0d,%0d) flush=%b cnt=%0d",
               req, alloc_gnt, alloc_prf[0], alloc_prf[1], fv, t0, t1, fl, free_count);
      for (int i = 0; i < k; i++) inflight_q.push_back(free_q.pop_front());
      for (int i = 0; i < 2; i++)
         if (fv[i]) begin
            free_q.push_back(tg[i]);
            pool_remove(tg[i]);
            pool_q.push_back(inflight_q.pop_front());
         end
      if (fl) begin
         free_q     = {inflight_q, free_q};
         inflight_q = {};
      end
   endtask

   task automatic rand_cycle();
      logic [1:0] req;
      logic [1:0] fv;
      logic       fl;
      int maxf, nf, t0, t1;
      req  = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 19) == 0);
      maxf = (inflight_q.size() < 2) ? inflight_q.size() : 2;
      nf   = $urandom_range(0, maxf);
      fv   = 2'b00;
      t0   = 0;
      t1   = 0;
      if (nf == 2) begin
         fv = 2'b11; t0 = pool_q[0]; t1 = pool_q[1];
      end else if (nf == 1) begin
         if ($urandom_range(0, 1) == 0) begin fv = 2'b01; t0 = pool_q[0]; end
         else begin fv = 2'b10; t1 = pool_q[0]; end
      end
      cycle(req, fv, t0, t1, fl);
   endtask

   initial begin
      reset_n    = 1'b0;
      alloc_req  = 2'b00;
      free_valid = 2'b00;
      free_prf[0] = '0;
      free_prf[1] = '0;
      flush      = 1'b0;

      // Drain the whole list two tags per cycle.
      do_reset();
      for (int c = 0; c < 32; c++) begin
         cycle(2'b11, 2'b00, 0, 0, 1'b0);
         check_val("drain_tag0", alloc_prf[0], ARCH + 2 * c);
         check_val("drain_tag1", alloc_prf[1], ARCH + 2 * c + 1);
      end
      cycle(2'b11, 2'b00, 0, 0, 1'b0);
      check_val("empty_gnt", alloc_gnt, 0);
      check_val("empty_count", free_count, 0);

      // Single remaining tag with both lanes requesting.
      do_reset();
      for (int c = 0; c < 31; c++) cycle(2'b11, 2'b00, 0, 0, 1'b0);
      cycle(2'b01, 2'b00, 0, 0, 1'b0);
      cycle(2'b11, 2'b00, 0, 0, 1'b0);
      check_val("last_gnt", alloc_gnt, 1);
      check_val("last_tag", alloc_prf[0], 127);
      cycle(2'b00, 2'b00, 0, 0, 1'b0);
      check_val("last_count", free_count, 0);

      // Refill from empty, lane 1 alone takes the oldest freed tag.
      cycle(2'b00, 2'b11, 5, 9, 1'b0);
      cycle(2'b10, 2'b00, 0, 0, 1'b0);
      check_val("refill_count", free_count, 2);
      check_val("refill_gnt", alloc_gnt, 2);
      check_val("refill_tag", alloc_prf[1], 5);

      // Flush rollback with a simultaneous free.
      do_reset();
      for (int c = 0; c < 5; c++) cycle(2'b11, 2'b00, 0, 0, 1'b0);
      cycle(2'b00, 2'b11, 0, 1, 1'b0);
      cycle(2'b00, 2'b01, 2, 0, 1'b0);
      cycle(2'b00, 2'b01, 3, 0, 1'b1);
      cycle(2'b01, 2'b00, 0, 0, 1'b0);
      check_val("flush_count", free_count, DEPTH);
      check_val("flush_tag", alloc_prf[0], 68);

      // Mixed random traffic, wrapping the pointers several times.
      do_reset();
      for (int c = 0; c < 200; c++) rand_cycle();

      // Asynchronous reset in the middle of traffic.
      do_reset();
      for (int c = 0; c < 20; c++) rand_cycle();

      // Freeing a tag that is already on the list.
      do_reset();
      @(negedge clk);
      free_valid  = 2'b01;
      free_prf[0] = 7'd70;
      @(negedge clk);
      free_valid = 2'b00;
      #1;
`ifdef FREELIST_CHECK_EN
      check_val("dfree_err", error, 1);
`else
      check_val("dfree_err", error, 0);
`endif
      @(negedge clk);
      #1;
`ifdef FREELIST_CHECK_EN
      check_val("dfree_sticky", error, 1);
`else
      check_val("dfree_sticky", error, 0);
`endif
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
